// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg : shared command/mode types for the ALU issue queue                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    AND = 2'b01,
    OR  = 2'b10,
    NOT = 2'b11
  } alu_mode_t;

  typedef struct packed {
    alu_mode_t        mode;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } iq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// +----------------------------------------------------------------------------+
// | alu_cmd_fifo : synchronous FIFO of ALU commands, flags from registered count|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  alu_cmd_t         mem_q [DEPTH];
  alu_cmd_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // A pop never frees a slot for a same-cycle push when full.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_queue.sv
// +----------------------------------------------------------------------------+
// | alu_issue_queue : buffers ALU commands, issues one at a time, tags results  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_mode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_mode,
  input  logic [3:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [SEQ_W-1:0] res_seq,
  output logic             busy
);

  iq_state_t        state_q, state_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  alu_mode_t        alu_mode_q, alu_mode_d;
  logic [3:0]       res_data_q, res_data_d;
  logic [SEQ_W-1:0] res_seq_q, res_seq_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             res_valid_q, res_valid_d;

  alu_cmd_t fifo_in, fifo_head;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign fifo_in   = '{mode: alu_mode_t'(cmd_mode), a: cmd_a, b: cmd_b};
  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_mode_d  = alu_mode_q;
    res_data_d  = res_data_q;
    res_seq_d   = res_seq_q;
    seq_cnt_d   = seq_cnt_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          alu_a_d    = fifo_head.a;
          alu_b_d    = fifo_head.b;
          alu_mode_d = fifo_head.mode;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands have been stable at the ALU for this whole cycle.
        res_data_d  = alu_result;
        res_seq_d   = seq_cnt_q;
        seq_cnt_d   = seq_cnt_q + SEQ_W'(1);
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            alu_a_d    = fifo_head.a;
            alu_b_d    = fifo_head.b;
            alu_mode_d = fifo_head.mode;
            state_d    = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= ADD;
      res_data_q  <= '0;
      res_seq_q   <= '0;
      seq_cnt_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_mode_q  <= alu_mode_d;
      res_data_q  <= res_data_d;
      res_seq_q   <= res_seq_d;
      seq_cnt_q   <= seq_cnt_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_mode  = alu_mode_q;
  assign res_data  = res_data_q;
  assign res_seq   = res_seq_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule

`default_nettype wire
